// File: rtl/uart7n_tx_arbiter_if.sv
// Handshake/bus bundle between requesters, the uart7n TX arbiter and the transmitter.
// Signals:
//   req_valid_i / req_data_i / req_ready_o : per-requester valid/ready character channel
//   grant_o                                : one-hot transmitter owner
//   uart_enable_tx_o / uart_data_tx_o      : start pulse and latched character to the TX
//   uart_tx_busy_i / uart_tx_data_sent_i   : transmitter status back to the arbiter
//   active_o / timeout_err_o               : arbiter status
// Modports: master = arbiter side, slave = requesters/transmitter side.
interface uart7n_tx_arbiter_if #(
  parameter int unsigned p_num_req    = 4,
  parameter int unsigned p_data_width = 7
);
  logic [p_num_req-1:0]              req_valid_i;
  logic [p_num_req*p_data_width-1:0] req_data_i;
  logic [p_num_req-1:0]              req_ready_o;
  logic [p_num_req-1:0]              grant_o;
  logic                              uart_enable_tx_o;
  logic [p_data_width-1:0]           uart_data_tx_o;
  logic                              uart_tx_busy_i;
  logic                              uart_tx_data_sent_i;
  logic                              active_o;
  logic                              timeout_err_o;

  modport master (
    input  req_valid_i, req_data_i, uart_tx_busy_i, uart_tx_data_sent_i,
    output req_ready_o, grant_o, uart_enable_tx_o, uart_data_tx_o, active_o, timeout_err_o
  );

  modport slave (
    output req_valid_i, req_data_i, uart_tx_busy_i, uart_tx_data_sent_i,
    input  req_ready_o, grant_o, uart_enable_tx_o, uart_data_tx_o, active_o, timeout_err_o
  );
endinterface

// File: rtl/uart7n_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one uart7n transmitter among p_num_req requesters.
// Ports:
//   clk_i : clock
//   rst_i : asynchronous active-high reset
//   bus   : uart7n_tx_arbiter_if.master (requester channel, TX start/data, TX status, status)
// All outputs are registered.
module uart7n_tx_arbiter #(
  parameter int unsigned p_num_req        = 4,
  parameter int unsigned p_data_width     = 7,
  parameter int unsigned p_timeout_cycles = 8192,
  parameter int unsigned p_gap_cycles     = 0
) (
  input logic                 clk_i,
  input logic                 rst_i,
  uart7n_tx_arbiter_if.master bus
);

  localparam int unsigned PTR_W = $clog2(p_num_req);
  localparam int unsigned CNT_W = $clog2(p_timeout_cycles + 1);
  localparam int unsigned GAP_W = (p_gap_cycles > 0) ? $clog2(p_gap_cycles + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(p_timeout_cycles - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((p_gap_cycles > 0) ? p_gap_cycles - 1 : 0);
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(p_num_req - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_DONE, S_GAP} state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [GAP_W-1:0]        gcnt_q, gcnt_d;
  logic                    sent_q;
  logic [p_num_req-1:0]    grant_q, grant_d;
  logic [p_num_req-1:0]    ready_q, ready_d;
  logic                    en_q, en_d;
  logic [p_data_width-1:0] data_q, data_d;
  logic                    active_q;
  logic                    to_q, to_d;

  logic                    win_found;
  logic [PTR_W-1:0]        win_idx;
  logic [p_num_req-1:0]    win_oh;
  logic [p_data_width-1:0] win_data;
  logic                    sent_rise;
  logic                    done;
  int unsigned             scan;

  logic [p_data_width-1:0] req_data_a [p_num_req];

  // Unpack the flat character bus into per-requester lanes
  for (genvar g = 0; g < p_num_req; g++) begin : g_unpack
    assign req_data_a[g] = bus.req_data_i[g*p_data_width +: p_data_width];
  end

  assign sent_rise = bus.uart_tx_data_sent_i & ~sent_q;

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      ptr_q    <= PTR_RST;
      cnt_q    <= '0;
      gcnt_q   <= '0;
      sent_q   <= 1'b0;
      grant_q  <= '0;
      ready_q  <= '0;
      en_q     <= 1'b0;
      data_q   <= '0;
      active_q <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      gcnt_q   <= gcnt_d;
      sent_q   <= bus.uart_tx_data_sent_i;
      grant_q  <= grant_d;
      ready_q  <= ready_d;
      en_q     <= en_d;
      data_q   <= data_d;
      active_q <= (state_d != S_IDLE);
      to_q     <= to_d;
    end
  end

  // Round-robin winner search plus next-state / next-output logic
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gcnt_d    = gcnt_q;
    grant_d   = grant_q;
    data_d    = data_q;
    ready_d   = '0;
    en_d      = 1'b0;
    to_d      = 1'b0;
    done      = 1'b0;
    win_found = 1'b0;
    win_idx   = '0;
    win_data  = '0;
    scan      = 0;

    // Scan upward from pointer+1, wrapping at p_num_req; first set bit wins
    for (int unsigned k = 1; k <= p_num_req; k++) begin
      scan = 32'(ptr_q) + k;
      if (scan >= p_num_req) scan = scan - p_num_req;
      if (!win_found && bus.req_valid_i[PTR_W'(scan)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(scan);
        win_data  = req_data_a[PTR_W'(scan)];
      end
    end
    win_oh = {{(p_num_req-1){1'b0}}, 1'b1} << win_idx;

    case (state_q)
      S_IDLE: begin
        if (win_found && !bus.uart_tx_busy_i) begin
          grant_d = win_oh;
          ready_d = win_oh;
          data_d  = win_data;
          en_d    = 1'b1;
          ptr_d   = win_idx;
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A sent edge in the timeout cycle takes precedence over the error
        if (sent_rise) begin
          done = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          to_d = 1'b1;
          done = 1'b1;
        end
        if (done) begin
          grant_d = '0;
          gcnt_d  = '0;
          state_d = (p_gap_cycles > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (gcnt_q == GAP_LAST) state_d = S_IDLE;
        else                    gcnt_d  = gcnt_q + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready_o      = ready_q;
  assign bus.grant_o          = grant_q;
  assign bus.uart_enable_tx_o = en_q;
  assign bus.uart_data_tx_o   = data_q;
  assign bus.active_o         = active_q;
  assign bus.timeout_err_o    = to_q;

endmodule

// File: tb/tb_uart7n_tx_arbiter.sv
// Directed bench for uart7n_tx_arbiter.
// dut_a: timeout 64, gap 0 (main function, rotation, priority, busy, reset)
// dut_b: timeout 16, gap 0 (timeout and sent/timeout collision)
// dut_c: timeout 16, gap 5 (gap spacing)
module tb_uart7n_tx_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned DW = 7;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  uart7n_tx_arbiter_if #(.p_num_req(NR), .p_data_width(DW)) ia ();
  uart7n_tx_arbiter_if #(.p_num_req(NR), .p_data_width(DW)) ib ();
  uart7n_tx_arbiter_if #(.p_num_req(NR), .p_data_width(DW)) ic ();

  uart7n_tx_arbiter #(.p_num_req(NR), .p_data_width(DW), .p_timeout_cycles(64), .p_gap_cycles(0))
    dut_a (.clk_i(clk), .rst_i(rst), .bus(ia));
  uart7n_tx_arbiter #(.p_num_req(NR), .p_data_width(DW), .p_timeout_cycles(16), .p_gap_cycles(0))
    dut_b (.clk_i(clk), .rst_i(rst), .bus(ib));
  uart7n_tx_arbiter #(.p_num_req(NR), .p_data_width(DW), .p_timeout_cycles(16), .p_gap_cycles(5))
    dut_c (.clk_i(clk), .rst_i(rst), .bus(ic));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ia.req_valid_i = '0; ia.req_data_i = '0; ia.uart_tx_busy_i = 1'b0; ia.uart_tx_data_sent_i = 1'b0;
    ib.req_valid_i = '0; ib.req_data_i = '0; ib.uart_tx_busy_i = 1'b0; ib.uart_tx_data_sent_i = 1'b0;
    ic.req_valid_i = '0; ic.req_data_i = '0; ic.uart_tx_busy_i = 1'b0; ic.uart_tx_data_sent_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) tick();
    total_cnt++;
    if ({ia.grant_o, ia.req_ready_o, ia.uart_enable_tx_o, ia.uart_data_tx_o, ia.active_o, ia.timeout_err_o} !== 18'h0)
      $display("FAIL reset_a: outputs=%h expected 0",
               {ia.grant_o, ia.req_ready_o, ia.uart_enable_tx_o, ia.uart_data_tx_o, ia.active_o, ia.timeout_err_o});
    else pass_cnt++;
    total_cnt++;
    if ({ib.grant_o, ib.req_ready_o, ib.uart_enable_tx_o, ib.uart_data_tx_o, ib.active_o, ib.timeout_err_o,
         ic.grant_o, ic.req_ready_o, ic.uart_enable_tx_o, ic.uart_data_tx_o, ic.active_o, ic.timeout_err_o} !== 36'h0)
      $display("FAIL reset_bc: outputs not all zero");
    else pass_cnt++;
    rst = 1'b0;
    repeat (2) tick();
    total_cnt++;
    if (ia.active_o !== 1'b0) $display("FAIL idle_after_reset: active=%b expected 0", ia.active_o);
    else pass_cnt++;
  endtask

  task automatic test_single();
    int bad;
    int extra;
    ia.req_data_i  = {7'h00, 7'h41, 7'h00, 7'h00};
    ia.req_valid_i = 4'b0100;
    tick();
    total_cnt++;
    if (ia.req_ready_o !== 4'b0100) $display("FAIL single_ready: got %b expected 0100", ia.req_ready_o);
    else pass_cnt++;
    total_cnt++;
    if (ia.uart_enable_tx_o !== 1'b1) $display("FAIL single_enable: got %b expected 1", ia.uart_enable_tx_o);
    else pass_cnt++;
    total_cnt++;
    if (ia.uart_data_tx_o !== 7'h41) $display("FAIL single_data: got %h expected 41", ia.uart_data_tx_o);
    else pass_cnt++;
    total_cnt++;
    if (ia.grant_o !== 4'b0100 || ia.active_o !== 1'b1)
      $display("FAIL single_grant: grant=%b active=%b expected 0100/1", ia.grant_o, ia.active_o);
    else pass_cnt++;
    ia.req_valid_i = '0;
    bad   = 0;
    extra = 0;
    repeat (49) begin
      tick();
      if (ia.grant_o !== 4'b0100 || ia.active_o !== 1'b1) bad++;
      if (ia.uart_enable_tx_o !== 1'b0 || ia.req_ready_o !== 4'b0000) extra++;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL single_hold: %0d cycles lost grant, expected 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (extra !== 0) $display("FAIL single_one_pulse: %0d extra pulse cycles, expected 0", extra);
    else pass_cnt++;
    ia.uart_tx_data_sent_i = 1'b1;
    tick();
    ia.uart_tx_data_sent_i = 1'b0;
    total_cnt++;
    if (ia.grant_o !== 4'b0000 || ia.active_o !== 1'b0 || ia.uart_data_tx_o !== 7'h41)
      $display("FAIL single_done: grant=%b active=%b data=%h expected 0000/0/41",
               ia.grant_o, ia.active_o, ia.uart_data_tx_o);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_rotation();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ia.req_data_i  = {7'h13, 7'h12, 7'h11, 7'h10};
    ia.req_valid_i = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      int exp_idx = n % 4;
      logic [3:0] exp_oh;
      logic [6:0] exp_data;
      int waited = 0;
      bit got = 1'b0;
      exp_oh   = 4'b0001 << exp_idx;
      exp_data = 7'h10 + 7'(exp_idx);
      while (!got && waited < 5) begin
        tick();
        waited++;
        if (ia.uart_enable_tx_o === 1'b1) got = 1'b1;
      end
      total_cnt++;
      if (!got) $display("FAIL rot_start_%0d: no enable within %0d cycles", n, waited);
      else pass_cnt++;
      total_cnt++;
      if (ia.grant_o !== exp_oh || ia.uart_data_tx_o !== exp_data)
        $display("FAIL rot_grant_%0d: grant=%b data=%h expected %b/%h",
                 n, ia.grant_o, ia.uart_data_tx_o, exp_oh, exp_data);
      else pass_cnt++;
      repeat (19) tick();
      ia.uart_tx_data_sent_i = 1'b1;
      tick();
      ia.uart_tx_data_sent_i = 1'b0;
    end
    ia.req_valid_i = '0;
    tick();
  endtask

  task automatic test_priority();
    int stray;
    rst = 1'b1;
    ia.req_data_i  = {7'h23, 7'h00, 7'h21, 7'h00};
    ia.req_valid_i = 4'b1010;
    tick();
    rst = 1'b0;
    tick();
    total_cnt++;
    if (ia.grant_o !== 4'b0010 || ia.uart_data_tx_o !== 7'h21)
      $display("FAIL prio_first: grant=%b data=%h expected 0010/21", ia.grant_o, ia.uart_data_tx_o);
    else pass_cnt++;
    ia.req_valid_i = 4'b1000;
    repeat (4) tick();
    ia.uart_tx_data_sent_i = 1'b1;
    tick();
    ia.uart_tx_data_sent_i = 1'b0;
    tick();
    total_cnt++;
    if (ia.grant_o !== 4'b1000 || ia.uart_data_tx_o !== 7'h23)
      $display("FAIL prio_second: grant=%b data=%h expected 1000/23", ia.grant_o, ia.uart_data_tx_o);
    else pass_cnt++;
    ia.req_valid_i = '0;
    repeat (3) tick();
    ia.uart_tx_data_sent_i = 1'b1;
    tick();
    ia.uart_tx_data_sent_i = 1'b0;
    // requester 3 raises valid while 0 is served, then withdraws
    ia.req_data_i  = {7'h33, 7'h00, 7'h00, 7'h30};
    ia.req_valid_i = 4'b0001;
    tick();
    total_cnt++;
    if (ia.grant_o !== 4'b0001) $display("FAIL wd_owner: grant=%b expected 0001", ia.grant_o);
    else pass_cnt++;
    ia.req_valid_i = 4'b1000;
    repeat (3) tick();
    ia.req_valid_i = 4'b0000;
    tick();
    ia.uart_tx_data_sent_i = 1'b1;
    tick();
    ia.uart_tx_data_sent_i = 1'b0;
    stray = 0;
    repeat (5) begin
      tick();
      if (ia.req_ready_o !== 4'b0000 || ia.uart_enable_tx_o !== 1'b0 ||
          ia.active_o !== 1'b0 || ia.grant_o !== 4'b0000) stray++;
    end
    total_cnt++;
    if (stray !== 0) $display("FAIL withdraw: %0d cycles with activity, expected 0", stray);
    else pass_cnt++;
  endtask

  task automatic test_busy();
    int stray;
    ia.uart_tx_busy_i = 1'b1;
    ia.req_data_i     = {7'h00, 7'h4b, 7'h00, 7'h00};
    ia.req_valid_i    = 4'b0100;
    stray = 0;
    repeat (5) begin
      tick();
      if (ia.req_ready_o !== 4'b0000 || ia.uart_enable_tx_o !== 1'b0 || ia.active_o !== 1'b0) stray++;
    end
    total_cnt++;
    if (stray !== 0) $display("FAIL busy_hold: %0d accepting cycles, expected 0", stray);
    else pass_cnt++;
    ia.uart_tx_busy_i = 1'b0;
    tick();
    total_cnt++;
    if (ia.req_ready_o !== 4'b0100 || ia.uart_enable_tx_o !== 1'b1 || ia.uart_data_tx_o !== 7'h4b)
      $display("FAIL busy_release: ready=%b en=%b data=%h expected 0100/1/4b",
               ia.req_ready_o, ia.uart_enable_tx_o, ia.uart_data_tx_o);
    else pass_cnt++;
    ia.req_valid_i = '0;
    tick();
    ia.uart_tx_data_sent_i = 1'b1;
    tick();
    ia.uart_tx_data_sent_i = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int early;
    ib.req_data_i  = {7'h00, 7'h00, 7'h56, 7'h55};
    ib.req_valid_i = 4'b0001;
    tick();
    total_cnt++;
    if (ib.uart_enable_tx_o !== 1'b1 || ib.grant_o !== 4'b0001)
      $display("FAIL to_start: en=%b grant=%b expected 1/0001", ib.uart_enable_tx_o, ib.grant_o);
    else pass_cnt++;
    ib.req_valid_i = '0;
    early = 0;
    for (int j = 1; j <= 16; j++) begin
      if (j == 16) ib.req_valid_i = 4'b0010;
      tick();
      if (j < 16 && (ib.timeout_err_o !== 1'b0 || ib.grant_o !== 4'b0001)) early++;
    end
    total_cnt++;
    if (early !== 0) $display("FAIL to_early: %0d bad cycles before timeout, expected 0", early);
    else pass_cnt++;
    total_cnt++;
    if (ib.timeout_err_o !== 1'b1 || ib.grant_o !== 4'b0000)
      $display("FAIL to_pulse: err=%b grant=%b expected 1/0000", ib.timeout_err_o, ib.grant_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ib.req_ready_o !== 4'b0010 || ib.uart_enable_tx_o !== 1'b1 || ib.timeout_err_o !== 1'b0)
      $display("FAIL to_next_accept: ready=%b en=%b err=%b expected 0010/1/0",
               ib.req_ready_o, ib.uart_enable_tx_o, ib.timeout_err_o);
    else pass_cnt++;
    ib.req_valid_i = '0;
    // sent edge lands on the timeout cycle
    repeat (15) tick();
    ib.uart_tx_data_sent_i = 1'b1;
    tick();
    ib.uart_tx_data_sent_i = 1'b0;
    total_cnt++;
    if (ib.timeout_err_o !== 1'b0 || ib.grant_o !== 4'b0000)
      $display("FAIL to_sent_wins: err=%b grant=%b expected 0/0000", ib.timeout_err_o, ib.grant_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ib.timeout_err_o !== 1'b0 || ib.active_o !== 1'b0)
      $display("FAIL to_after_sent: err=%b active=%b expected 0/0", ib.timeout_err_o, ib.active_o);
    else pass_cnt++;
  endtask

  task automatic test_gap();
    int n;
    bit got;
    ic.req_data_i  = {7'h00, 7'h00, 7'h00, 7'h30};
    ic.req_valid_i = 4'b0001;
    tick();
    total_cnt++;
    if (ic.uart_enable_tx_o !== 1'b1) $display("FAIL gap_start: en=%b expected 1", ic.uart_enable_tx_o);
    else pass_cnt++;
    repeat (3) tick();
    ic.uart_tx_data_sent_i = 1'b1;
    tick();
    ic.uart_tx_data_sent_i = 1'b0;
    total_cnt++;
    if (ic.grant_o !== 4'b0000 || ic.active_o !== 1'b1)
      $display("FAIL gap_enter: grant=%b active=%b expected 0000/1", ic.grant_o, ic.active_o);
    else pass_cnt++;
    n   = 0;
    got = 1'b0;
    while (!got && n < 12) begin
      tick();
      n++;
      if (ic.uart_enable_tx_o === 1'b1) got = 1'b1;
    end
    total_cnt++;
    if (!got || n !== 6) $display("FAIL gap_spacing: accept after %0d edges (seen=%b), expected 6", n, got);
    else pass_cnt++;
    ic.req_valid_i = '0;
    repeat (2) tick();
    ic.uart_tx_data_sent_i = 1'b1;
    tick();
    ic.uart_tx_data_sent_i = 1'b0;
    repeat (7) tick();
  endtask

  task automatic test_async_reset();
    int stray;
    ia.req_data_i  = {7'h00, 7'h00, 7'h00, 7'h11};
    ia.req_valid_i = 4'b0001;
    tick();
    ia.req_valid_i = '0;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({ia.grant_o, ia.req_ready_o, ia.uart_enable_tx_o, ia.uart_data_tx_o, ia.active_o, ia.timeout_err_o} !== 18'h0)
      $display("FAIL async_reset: outputs=%h expected 0 before next edge",
               {ia.grant_o, ia.req_ready_o, ia.uart_enable_tx_o, ia.uart_data_tx_o, ia.active_o, ia.timeout_err_o});
    else pass_cnt++;
    #1;
    rst = 1'b0;
    ia.uart_tx_data_sent_i = 1'b1;
    stray = 0;
    repeat (4) begin
      tick();
      if (ia.grant_o !== 4'b0000 || ia.active_o !== 1'b0 ||
          ia.timeout_err_o !== 1'b0 || ia.uart_enable_tx_o !== 1'b0) stray++;
    end
    ia.uart_tx_data_sent_i = 1'b0;
    total_cnt++;
    if (stray !== 0) $display("FAIL late_sent: %0d cycles with activity, expected 0", stray);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_rotation();
    test_priority();
    test_busy();
    test_timeout();
    test_gap();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
